// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package sevenseg_pkg;
   typedef enum logic [1:0] {S_OFF, S_DRIVE, S_GAP} scan_state_t;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic       AN_OFF_BIT = 1'b1;
endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake bundle. A word transfers on a rising edge where load_valid && load_ready;
// load_data is only meaningful while load_valid is high, and load_valid may stay high across words.
interface sevenseg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 3
);
   logic                          load_valid;
   logic [NUM_DIGITS*DIGIT_W-1:0] load_data;
   logic                          load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/sevenseg_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module sevenseg_decoder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value,
   output logic [6:0]       seg
);
   logic [31:0] v;

   always_comb begin
      v = 32'(value);
      case (v)
         32'd0:   seg = 7'h40;
         32'd1:   seg = 7'h79;
         32'd2:   seg = 7'h24;
         32'd3:   seg = 7'h30;
         32'd4:   seg = 7'h19;
         32'd5:   seg = 7'h12;
         32'd6:   seg = 7'h02;
         32'd7:   seg = 7'h78;
         32'd8:   seg = 7'h00;
         32'd9:   seg = 7'h10;
         32'd10:  seg = 7'h08;
         32'd11:  seg = 7'h03;
         32'd12:  seg = 7'h46;
         32'd13:  seg = 7'h21;
         32'd14:  seg = 7'h06;
         32'd15:  seg = 7'h0E;
         // Values beyond hex show a lone middle bar.
         default: seg = 7'h3F;
      endcase
   end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode display through one shared decoder, with
// frame-aligned updates of the displayed word so a new value never tears mid-frame.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_W      = 3,
   parameter int DWELL_CYCLES = 100000,
   parameter int GAP_CYCLES   = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   sevenseg_scan_ctrl_if.slave   bus,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic                  frame_done,
   output scan_state_t           state_dbg
);
   localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int WORD_W  = NUM_DIGITS * DIGIT_W;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{AN_OFF_BIT}};

   scan_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] shadow, pending;
   logic              pend_full, load_ready_q;

   logic              adv, wrap, copy, xfer;
   logic [IDX_W-1:0]  idx_nxt;
   logic [WORD_W-1:0] shadow_nxt;
   logic [DIGIT_W-1:0] digit_sel;
   logic [6:0]        seg_dec;
   logic [NUM_DIGITS-1:0] an_sel;

   // Decoder and anode select look at the idx/shadow that will be live after this edge,
   // so segments and anodes change together with the state register.
   always_comb begin
      adv = enable && (((state == S_DRIVE) && (cnt == DWELL_LAST) && (GAP_CYCLES == 0)) ||
                       ((state == S_GAP) && (cnt == GAP_LAST)));
      wrap = adv && (idx == IDX_LAST);
      if (!enable || state == S_OFF) idx_nxt = '0;
      else if (adv)                  idx_nxt = wrap ? '0 : idx + 1'b1;
      else                           idx_nxt = idx;
      copy       = pend_full && ((state == S_OFF) || wrap);
      xfer       = bus.load_valid && load_ready_q;
      shadow_nxt = copy ? pending : shadow;
      digit_sel  = shadow_nxt[32'(idx_nxt)*DIGIT_W +: DIGIT_W];
      an_sel     = ~(NUM_DIGITS'(1) << idx_nxt);
   end

   sevenseg_decoder #(.WIDTH(DIGIT_W)) u_dec (.value(digit_sel), .seg(seg_dec));

   assign bus.load_ready = load_ready_q;
   assign state_dbg      = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_OFF;
         idx          <= '0;
         cnt          <= '0;
         shadow       <= '0;
         pending      <= '0;
         pend_full    <= 1'b0;
         load_ready_q <= 1'b1;
         seg_out      <= SEG_BLANK;
         an_out       <= AN_ALL_OFF;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (copy) begin
            shadow    <= pending;
            pend_full <= 1'b0;
         end
         if (xfer) begin
            pending   <= bus.load_data;
            pend_full <= 1'b1;
         end
         // Ready lags the pending slot emptying by one edge.
         load_ready_q <= xfer ? 1'b0 : !pend_full;
         if (!enable) begin
            state   <= S_OFF;
            idx     <= '0;
            cnt     <= '0;
            seg_out <= SEG_BLANK;
            an_out  <= AN_ALL_OFF;
         end else begin
            case (state)
               S_OFF: begin
                  state   <= S_DRIVE;
                  idx     <= '0;
                  cnt     <= '0;
                  seg_out <= seg_dec;
                  an_out  <= an_sel;
               end
               S_DRIVE: begin
                  if (cnt == DWELL_LAST) begin
                     cnt <= '0;
                     if (GAP_CYCLES > 0) begin
                        state   <= S_GAP;
                        seg_out <= SEG_BLANK;
                        an_out  <= AN_ALL_OFF;
                     end else begin
                        idx        <= idx_nxt;
                        frame_done <= wrap;
                        seg_out    <= seg_dec;
                        an_out     <= an_sel;
                     end
                  end else begin
                     cnt     <= cnt + 1'b1;
                     seg_out <= seg_dec;
                     an_out  <= an_sel;
                  end
               end
               S_GAP: begin
                  if (cnt == GAP_LAST) begin
                     state      <= S_DRIVE;
                     cnt        <= '0;
                     idx        <= idx_nxt;
                     frame_done <= wrap;
                     seg_out    <= seg_dec;
                     an_out     <= an_sel;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= S_OFF;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench: dut0 scans with a one-cycle gap, dut1 scans back-to-back without a gap.
module tb_sevenseg_scan_ctrl;
   import sevenseg_pkg::*;

   logic clk = 1'b0;
   logic rst_n, enable0, enable1;
   logic [6:0] seg0, seg1;
   logic [3:0] an0, an1;
   logic fd0, fd1;
   scan_state_t st0, st1;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   logic [11:0] exp_q[$];
   logic [6:0]  seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(3)) bus0 ();
   sevenseg_scan_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(3)) bus1 ();

   sevenseg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_W(3), .DWELL_CYCLES(4), .GAP_CYCLES(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable0), .bus(bus0),
      .seg_out(seg0), .an_out(an0), .frame_done(fd0), .state_dbg(st0));

   sevenseg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_W(3), .DWELL_CYCLES(4), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable1), .bus(bus1),
      .seg_out(seg1), .an_out(an1), .frame_done(fd1), .state_dbg(st1));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Expected {frame_done, an, seg} for each cycle of one frame.
   task automatic push_frame(input logic [11:0] word, input logic fd_first, input int gap);
      logic [2:0] d;
      for (int k = 0; k < 4; k++) begin
         d = word[k*3 +: 3];
         for (int c = 0; c < 4; c++)
            exp_q.push_back({(k == 0 && c == 0) ? fd_first : 1'b0, ~(4'b0001 << k), seg_tab[d]});
         if (gap != 0) exp_q.push_back({1'b0, 4'hF, 7'h7F});
      end
   endtask

   task automatic run(input int n, input int sel);
      logic [11:0] e, obs;
      for (int i = 0; i < n; i++) begin
         step();
         obs = (sel != 0) ? {fd1, an1, seg1} : {fd0, an0, seg0};
         if (exp_q.size() == 0) chk("scan_queue_empty", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            chk((sel != 0) ? "scan_nogap" : "scan_gap", 32'(obs), 32'(e));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; enable0 = 1'b1; enable1 = 1'b0;
      bus0.load_valid = 1'b1; bus0.load_data = 12'hABC;
      bus1.load_valid = 1'b0; bus1.load_data = 12'h000;

      // Reset dominates enable and load_valid.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_seg", 32'(seg0), 32'h7F);
         chk("rst_an", 32'(an0), 32'hF);
         chk("rst_ready", 32'(bus0.load_ready), 32'd1);
         chk("rst_fd", 32'(fd0), 32'd0);
      end
      chk("rst_state", 32'(st0), 32'(S_OFF));
      chk("rst_seg1", 32'(seg1), 32'h7F);

      // Load while disabled, then scan.
      rst_n = 1'b1; enable0 = 1'b0; bus0.load_data = 12'h688;
      step();
      chk("off_load_ready0", 32'(bus0.load_ready), 32'd0);
      bus0.load_valid = 1'b0;
      step();
      chk("off_copy_ready0", 32'(bus0.load_ready), 32'd0);
      step();
      chk("off_ready1", 32'(bus0.load_ready), 32'd1);
      chk("off_an", 32'(an0), 32'hF);
      enable0 = 1'b1;
      push_frame(12'h688, 1'b0, 1);
      run(20, 0);

      // New word during digit-1 dwell is held until the frame boundary.
      push_frame(12'h688, 1'b1, 1);
      run(7, 0);
      bus0.load_valid = 1'b1; bus0.load_data = 12'hFFF;
      run(1, 0);
      chk("load_ready_drop", 32'(bus0.load_ready), 32'd0);
      bus0.load_data = 12'h249;
      run(12, 0);
      chk("ready_held_low", 32'(bus0.load_ready), 32'd0);
      bus0.load_valid = 1'b0;
      push_frame(12'hFFF, 1'b1, 1);
      run(1, 0);
      chk("ready_boundary", 32'(bus0.load_ready), 32'd0);
      run(1, 0);
      chk("ready_after_boundary", 32'(bus0.load_ready), 32'd1);
      run(18, 0);
      chk("ready_stays", 32'(bus0.load_ready), 32'd1);

      // Drop enable in the second cycle of digit 2, then restart from digit 0.
      push_frame(12'hFFF, 1'b1, 1);
      run(12, 0);
      exp_q.delete();
      enable0 = 1'b0;
      exp_q.push_back({1'b0, 4'hF, 7'h7F});
      exp_q.push_back({1'b0, 4'hF, 7'h7F});
      run(2, 0);
      chk("disabled_state", 32'(st0), 32'(S_OFF));
      enable0 = 1'b1;
      push_frame(12'hFFF, 1'b0, 1);
      run(20, 0);
      push_frame(12'hFFF, 1'b1, 1);
      run(5, 0);
      exp_q.delete();

      // Reset mid-scan discards a pending word and clears the shadow.
      bus0.load_valid = 1'b1; bus0.load_data = 12'h123;
      step();
      chk("pend_taken", 32'(bus0.load_ready), 32'd0);
      bus0.load_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_seg", 32'(seg0), 32'h7F);
      chk("midrst_an", 32'(an0), 32'hF);
      chk("midrst_ready", 32'(bus0.load_ready), 32'd1);
      chk("midrst_fd", 32'(fd0), 32'd0);
      rst_n = 1'b1;
      push_frame(12'h000, 1'b0, 1);
      run(20, 0);
      push_frame(12'h000, 1'b1, 1);
      run(20, 0);

      // No-gap instance: digits back-to-back, frame every 16 cycles.
      enable0 = 1'b0;
      bus1.load_valid = 1'b1; bus1.load_data = 12'h688;
      step();
      bus1.load_valid = 1'b0;
      step();
      step();
      chk("nogap_ready", 32'(bus1.load_ready), 32'd1);
      enable1 = 1'b1;
      push_frame(12'h688, 1'b0, 0);
      run(16, 1);
      push_frame(12'h688, 1'b1, 0);
      run(16, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
